// File: rtl/pe_adder_arbiter.sv
// pe_adder_arbiter
//   Round-robin sequencer that shares one PE adder among N requesters. It accepts
//   one operand pair from the granted requester and issues it to the adder. It
//   waits for the sum and returns it to that same requester, then re-arbitrates.
//   Only one transaction is in flight at any time.
// Ports
//   clk, rst_n              rising-edge clock, async active-low reset
//   req_valid/req_ready     per-requester operand handshake (ready is one-hot)
//   req_a, req_b            packed operands, slice i = [i*DWIDTH +: DWIDTH]
//   add_valid/add_ready     operand handshake towards the adder
//   add_a, add_b            operands to the adder, held until accepted
//   add_res_valid/_ready    sum handshake from the adder
//   add_res                 sum from the adder
//   rsp_valid/rsp_ready     per-requester sum handshake (valid is one-hot)
//   rsp_data                returned sum on a shared bus
//   busy                    high whenever a transaction is in progress
//   done_cnt                completed transactions, wraps modulo 2^CNT_W
module pe_adder_arbiter #(
   parameter int unsigned N      = 4,
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          req_valid,
   input  logic [N*DWIDTH-1:0]   req_a,
   input  logic [N*DWIDTH-1:0]   req_b,
   output logic [N-1:0]          req_ready,
   output logic                  add_valid,
   input  logic                  add_ready,
   output logic [DWIDTH-1:0]     add_a,
   output logic [DWIDTH-1:0]     add_b,
   input  logic                  add_res_valid,
   output logic                  add_res_ready,
   input  logic [DWIDTH-1:0]     add_res,
   output logic [N-1:0]          rsp_valid,
   input  logic [N-1:0]          rsp_ready,
   output logic [DWIDTH-1:0]     rsp_data,
   output logic                  busy,
   output logic [CNT_W-1:0]      done_cnt
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_RETURN = 2'd3;

   logic [1:0]        state_q,    state_d;
   logic [PW-1:0]     rr_ptr_q,   rr_ptr_d;
   logic [PW-1:0]     grant_q,    grant_d;
   logic [DWIDTH-1:0] add_a_q,    add_a_d;
   logic [DWIDTH-1:0] add_b_q,    add_b_d;
   logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

   logic [PW-1:0]     sel;
   logic              sel_found;
   logic [N-1:0]      sel_oh;
   logic [N-1:0]      grant_oh;

   // First valid requester at or after rr_ptr, wrapping modulo N.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!sel_found && req_valid[(32'(rr_ptr_q) + k) % N]) begin
            sel       = PW'((32'(rr_ptr_q) + k) % N);
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_oh             = '0;
      sel_oh[sel]        = sel_found;
      grant_oh           = '0;
      grant_oh[grant_q]  = 1'b1;
   end

   // Gated by rst_n so no accept is offered while reset is asserted.
   assign req_ready     = (rst_n && state_q == ST_IDLE) ? sel_oh : '0;
   assign add_valid     = (state_q == ST_ISSUE);
   assign add_res_ready = (state_q == ST_WAIT);
   assign rsp_valid     = (state_q == ST_RETURN) ? grant_oh : '0;
   assign add_a         = add_a_q;
   assign add_b         = add_b_q;
   assign rsp_data      = rsp_data_q;
   assign busy          = (state_q != ST_IDLE);
   assign done_cnt      = done_cnt_q;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      add_a_d    = add_a_q;
      add_b_d    = add_b_q;
      rsp_data_d = rsp_data_q;
      done_cnt_d = done_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               add_a_d = req_a[sel*DWIDTH +: DWIDTH];
               add_b_d = req_b[sel*DWIDTH +: DWIDTH];
               grant_d = sel;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (add_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (add_res_valid) begin
               rsp_data_d = add_res;
               state_d    = ST_RETURN;
            end
         end
         ST_RETURN: begin
            // Only the granted requester's rsp_ready completes the transfer.
            if (rsp_ready[grant_q]) begin
               done_cnt_d = done_cnt_q + CNT_W'(1);
               rr_ptr_d   = (grant_q == PW'(N - 1)) ? '0 : grant_q + PW'(1);
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         add_a_q    <= '0;
         add_b_q    <= '0;
         rsp_data_q <= '0;
         done_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         add_a_q    <= add_a_d;
         add_b_q    <= add_b_d;
         rsp_data_q <= rsp_data_d;
         done_cnt_q <= done_cnt_d;
      end
   end

endmodule

// File: tb/tb_pe_adder_arbiter.sv
// tb_pe_adder_arbiter
//   Directed bench for pe_adder_arbiter (N=4, DWIDTH=8, CNT_W=4 so that the
//   completion counter wrap is reachable). The bench plays the requesters and
//   the adder; expected grants, operands and sums are hand-computed constants.
module tb_pe_adder_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 4;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_a;
   logic [N*DW-1:0] req_b;
   logic [N-1:0]    req_ready;
   logic            add_valid;
   logic            add_ready;
   logic [DW-1:0]   add_a;
   logic [DW-1:0]   add_b;
   logic            add_res_valid;
   logic            add_res_ready;
   logic [DW-1:0]   add_res;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [DW-1:0]   rsp_data;
   logic            busy;
   logic [CW-1:0]   done_cnt;

   int n_cmp;
   int n_err;
   int cnt_model;

   pe_adder_arbiter #(.N(N), .DWIDTH(DW), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_ready     (req_ready),
      .add_valid     (add_valid),
      .add_ready     (add_ready),
      .add_a         (add_a),
      .add_b         (add_b),
      .add_res_valid (add_res_valid),
      .add_res_ready (add_res_ready),
      .add_res       (add_res),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .busy          (busy),
      .done_cnt      (done_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full transaction. Entered and left just after a falling edge.
   task automatic run_txn(input string tag, input logic [N-1:0] valids,
                          input logic [N*DW-1:0] as, input logic [N*DW-1:0] bs,
                          input bit hold, input int exp_g,
                          input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                          input logic [DW-1:0] es, input int add_stall, input int rsp_stall);
      logic [N-1:0] oh;
      int waits;
      oh = '0;
      oh[exp_g] = 1'b1;
      req_valid = valids;
      req_a = as;
      req_b = bs;
      #1;
      waits = 0;
      while (req_ready == '0 && waits < 20) begin
         @(negedge clk); #1;
         waits++;
      end
      check({tag, "_grant"}, 32'(req_ready), 32'(oh));
      @(negedge clk);
      if (!hold) req_valid = '0;
      #1;
      check({tag, "_add_valid"}, 32'(add_valid), 1);
      check({tag, "_add_a"}, 32'(add_a), 32'(ea));
      check({tag, "_add_b"}, 32'(add_b), 32'(eb));
      for (int i = 0; i < add_stall; i++) begin
         @(negedge clk); #1;
         check({tag, "_stall_add_valid"}, 32'(add_valid), 1);
         check({tag, "_stall_add_ab"}, 32'({add_a, add_b}), 32'({ea, eb}));
         check({tag, "_stall_req_ready"}, 32'(req_ready), 0);
      end
      add_ready = 1'b1;
      @(negedge clk);
      add_ready = 1'b0;
      #1;
      check({tag, "_wait_add_valid"}, 32'(add_valid), 0);
      check({tag, "_wait_res_ready"}, 32'(add_res_ready), 1);
      // Adder model: wraps modulo 2^DW.
      add_res = add_a + add_b;
      add_res_valid = 1'b1;
      @(negedge clk);
      add_res_valid = 1'b0;
      add_res = '0;
      #1;
      check({tag, "_ret_res_ready"}, 32'(add_res_ready), 0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(oh));
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'(es));
      for (int i = 0; i < rsp_stall; i++) begin
         rsp_ready = ~oh;
         @(negedge clk); #1;
         check({tag, "_stall_rsp_valid"}, 32'(rsp_valid), 32'(oh));
         check({tag, "_stall_rsp_data"}, 32'(rsp_data), 32'(es));
         check({tag, "_stall_req_ready2"}, 32'(req_ready), 0);
      end
      rsp_ready = oh;
      @(negedge clk);
      rsp_ready = '0;
      #1;
      cnt_model = (cnt_model + 1) % 16;
      check({tag, "_rsp_done"}, 32'(rsp_valid), 0);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'(cnt_model));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cnt_model = 0;
      rst_n = 1'b0;
      req_valid = '1;
      req_a = '0;
      req_b = '0;
      add_ready = 1'b0;
      add_res_valid = 1'b0;
      add_res = '0;
      rsp_ready = '0;
      @(negedge clk); @(negedge clk); #1;
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_outputs", 32'({add_valid, add_res_ready, rsp_valid, busy}), 0);
      check("rst_data", 32'({add_a, add_b, rsp_data}), 0);
      check("rst_done_cnt", 32'(done_cnt), 0);
      req_valid = '0;
      rst_n = 1'b1;
      @(negedge clk);

      // Single requests, including an 8-bit wrap.
      run_txn("t1", 4'b0001, 32'h0000_0012, 32'h0000_0034, 1'b0, 0, 8'h12, 8'h34, 8'h46, 0, 0);
      run_txn("t2", 4'b0100, 32'h00F0_0000, 32'h0020_0000, 1'b0, 2, 8'hF0, 8'h20, 8'h10, 0, 0);
      run_txn("t2b", 4'b1000, 32'h0100_0000, 32'h0100_0000, 1'b0, 3, 8'h01, 8'h01, 8'h02, 0, 0);

      // All requesters held valid: strict rotation starting from requester 0.
      for (int i = 0; i < 5; i++) begin
         logic [DW-1:0] v;
         v = DW'((i % 4) * 2);
         run_txn("t3", 4'b1111, 32'h0302_0100, 32'h0302_0100, 1'b1, i % 4,
                 DW'(i % 4), DW'(i % 4), v, 0, 0);
      end

      // Stalls on both handshakes; rr_ptr now points at requester 1.
      run_txn("t4", 4'b1111, 32'h3525_1505, 32'h3323_1303, 1'b1, 1, 8'h15, 8'h13, 8'h28, 5, 3);
      req_valid = '0;

      // Reset while waiting for the sum; late sum must be ignored.
      req_valid = 4'b0100;
      req_a = 32'h0040_0000;
      req_b = 32'h0001_0000;
      #1;
      check("t5_grant", 32'(req_ready), 32'h4);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("t5_issue", 32'(add_valid), 1);
      add_ready = 1'b1;
      @(negedge clk);
      add_ready = 1'b0;
      #1;
      check("t5_wait", 32'(add_res_ready), 1);
      req_valid = 4'b1111;
      rst_n = 1'b0;
      #1;
      check("t5_rst_req_ready", 32'(req_ready), 0);
      check("t5_rst_outputs", 32'({add_valid, add_res_ready, rsp_valid, busy}), 0);
      check("t5_rst_data", 32'({add_a, add_b, rsp_data}), 0);
      check("t5_rst_done_cnt", 32'(done_cnt), 0);
      @(negedge clk);
      req_valid = '0;
      rst_n = 1'b1;
      add_res = 8'hAA;
      add_res_valid = 1'b1;
      #1;
      check("t5_late_res_ready", 32'(add_res_ready), 0);
      @(negedge clk);
      add_res_valid = 1'b0;
      add_res = '0;
      #1;
      check("t5_late_state", 32'({busy, rsp_valid, rsp_data}), 0);
      cnt_model = 0;
      run_txn("t5_after", 4'b1010, 32'h9900_0700, 32'h0100_0800, 1'b0, 1, 8'h07, 8'h08, 8'h0F, 0, 0);

      // Completion counter wrap with a 4-bit counter.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cnt_model = 0;
      for (int k = 0; k < 17; k++) begin
         run_txn("t6", 4'b0001, 32'(k), 32'h1, 1'b0, 0, DW'(k), 8'h01, DW'(k + 1), 0, 0);
      end
      check("t6_wrapped_cnt", 32'(done_cnt), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
